// File: rtl/mig_ui_emu.sv
// Block-RAM backed stand-in for the DDR3 MIG user interface: command/write-data FIFOs, byte masks,
// fixed read latency and calibration delay. Define MIG_UI_EMU_BACKPRESSURE_EN for LFSR-driven ready stalls.
module mig_ui_emu #(
    parameter int DATA_W       = 256,
    parameter int ADDR_W       = 30,
    parameter int ADDR_LSB     = 3,
    parameter int MEM_AW       = 10,
    parameter int RD_LAT       = 4,
    parameter int CMD_DEPTH    = 4,
    parameter int WDF_DEPTH    = 4,
    parameter int CALIB_CYCLES = 32
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst,
    output logic                  ui_clk_sync_rst,
    output logic                  init_calib_complete,
    input  logic [ADDR_W-1:0]     app_addr,
    input  logic [2:0]            app_cmd,
    input  logic                  app_en,
    output logic                  app_rdy,
    input  logic [DATA_W-1:0]     app_wdf_data,
    input  logic [DATA_W/8-1:0]   app_wdf_mask,
    input  logic                  app_wdf_wren,
    input  logic                  app_wdf_end,
    output logic                  app_wdf_rdy,
    output logic [DATA_W-1:0]     app_rd_data,
    output logic                  app_rd_data_valid,
    output logic                  app_rd_data_end,
    input  logic                  app_ref_req,
    input  logic                  app_zq_req,
    output logic                  app_ref_ack,
    output logic                  app_zq_ack,
    output logic                  app_sr_active,
    output logic                  cmd_err
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CPW    = $clog2(CMD_DEPTH);
    localparam int WPW    = $clog2(WDF_DEPTH);
    localparam int CNT_W  = $clog2(CALIB_CYCLES + 4) + 1;
    localparam int WORDS  = 2 ** MEM_AW;

    localparam logic [CPW:0]        CMD_FULL   = (CPW + 1)'(CMD_DEPTH);
    localparam logic [WPW:0]        WDF_FULL   = (WPW + 1)'(WDF_DEPTH);
    localparam logic [CPW-1:0]      CPTR_ONE   = CPW'(1);
    localparam logic [WPW-1:0]      WPTR_ONE   = WPW'(1);
    localparam logic [CNT_W-1:0]    RST_LAST   = CNT_W'(3);
    localparam logic [CNT_W-1:0]    CALIB_LAST = CNT_W'(CALIB_CYCLES - 1);
    localparam logic [DATA_W-1:0]   UNWRITTEN  = DATA_W'(32'hDEADBEEF);

    localparam logic [1:0] ST_IDLE_RST = 2'd0;
    localparam logic [1:0] ST_CALIB    = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;
    localparam logic [2:0] CMD_WR      = 3'b000;
    localparam logic [2:0] CMD_RD      = 3'b001;

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CPW-1:0]         cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
    logic [CPW:0]           cmd_cnt_q, cmd_cnt_d;
    logic [WPW-1:0]         wdf_wp_q, wdf_wp_d, wdf_rp_q, wdf_rp_d;
    logic [WPW:0]           wdf_cnt_q, wdf_cnt_d;
    logic [WORDS-1:0]       bitmap_q, bitmap_d;
    logic [RD_LAT-1:0]      rd_vld_q, rd_vld_d;
    logic                   out_vld_q, out_vld_d;
    logic [DATA_W-1:0]      out_data_q, out_data_d;
    logic                   err_q, err_d;
    logic                   ref_ack_q, zq_ack_q;

    logic [2:0]             cmd_op_mem  [CMD_DEPTH];
    logic [MEM_AW-1:0]      cmd_idx_mem [CMD_DEPTH];
    logic [DATA_W-1:0]      wdf_data_mem [WDF_DEPTH];
    logic [MASK_W-1:0]      wdf_mask_mem [WDF_DEPTH];
    logic [DATA_W-1:0]      mem [WORDS];
    logic [DATA_W-1:0]      rd_data_q [RD_LAT];

    logic                   run, cmd_push, wdf_push, cmd_pop;
    logic                   issue_rd, issue_wr, issue_drop;
    logic                   cmd_rdy, wdf_rdy, bp_cmd_ok, bp_wdf_ok;
    logic [2:0]             head_op;
    logic [MEM_AW-1:0]      head_idx;
    logic                   unused_inputs;

    assign unused_inputs = ^{app_wdf_end, app_addr};

`ifdef MIG_UI_EMU_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign bp_cmd_ok = (lfsr_q[1:0] != 2'b00);
    assign bp_wdf_ok = (lfsr_q[3:2] != 2'b00);

    always_ff @(posedge sys_clk_i or negedge sys_rst) begin
        if (!sys_rst) lfsr_q <= 16'hACE1;
        else          lfsr_q <= lfsr_d;
    end
`else
    assign bp_cmd_ok = 1'b1;
    assign bp_wdf_ok = 1'b1;
`endif

    always_comb begin
        run      = (state_q == ST_RUN);
        cmd_rdy  = run && (cmd_cnt_q != CMD_FULL) && bp_cmd_ok;
        wdf_rdy  = run && (wdf_cnt_q != WDF_FULL) && bp_wdf_ok;
        cmd_push = app_en && cmd_rdy;
        wdf_push = app_wdf_wren && wdf_rdy;
        head_op  = cmd_op_mem[cmd_rp_q];
        head_idx = cmd_idx_mem[cmd_rp_q];

        // A write at the head waits for its data beat and holds back everything behind it.
        issue_rd   = run && (cmd_cnt_q != '0) && (head_op == CMD_RD);
        issue_wr   = run && (cmd_cnt_q != '0) && (head_op == CMD_WR) && (wdf_cnt_q != '0);
        issue_drop = run && (cmd_cnt_q != '0) && (head_op != CMD_RD) && (head_op != CMD_WR);
        cmd_pop    = issue_rd || issue_wr || issue_drop;

        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            ST_IDLE_RST: if (cnt_q == RST_LAST) begin
                state_d = ST_CALIB;
                cnt_d   = '0;
            end
            ST_CALIB: if (cnt_q == CALIB_LAST) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
            ST_RUN: cnt_d = '0;
            default: begin
                state_d = ST_IDLE_RST;
                cnt_d   = '0;
            end
        endcase

        cmd_wp_d  = cmd_push ? cmd_wp_q + CPTR_ONE : cmd_wp_q;
        cmd_rp_d  = cmd_pop  ? cmd_rp_q + CPTR_ONE : cmd_rp_q;
        cmd_cnt_d = cmd_cnt_q;
        if (cmd_push && !cmd_pop) cmd_cnt_d = cmd_cnt_q + (CPW + 1)'(1);
        if (!cmd_push && cmd_pop) cmd_cnt_d = cmd_cnt_q - (CPW + 1)'(1);

        wdf_wp_d  = wdf_push ? wdf_wp_q + WPTR_ONE : wdf_wp_q;
        wdf_rp_d  = issue_wr ? wdf_rp_q + WPTR_ONE : wdf_rp_q;
        wdf_cnt_d = wdf_cnt_q;
        if (wdf_push && !issue_wr) wdf_cnt_d = wdf_cnt_q + (WPW + 1)'(1);
        if (!wdf_push && issue_wr) wdf_cnt_d = wdf_cnt_q - (WPW + 1)'(1);

        bitmap_d = bitmap_q;
        if (issue_wr) bitmap_d[head_idx] = 1'b1;

        err_d      = err_q || (cmd_push && (app_cmd != CMD_RD) && (app_cmd != CMD_WR));
        rd_vld_d   = (rd_vld_q << 1) | RD_LAT'(issue_rd);
        out_vld_d  = rd_vld_q[RD_LAT-1];
        out_data_d = rd_vld_q[RD_LAT-1] ? rd_data_q[RD_LAT-1] : out_data_q;
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q    <= ST_IDLE_RST;
            cnt_q      <= '0;
            cmd_wp_q   <= '0;
            cmd_rp_q   <= '0;
            cmd_cnt_q  <= '0;
            wdf_wp_q   <= '0;
            wdf_rp_q   <= '0;
            wdf_cnt_q  <= '0;
            bitmap_q   <= '0;
            rd_vld_q   <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            err_q      <= 1'b0;
            ref_ack_q  <= 1'b0;
            zq_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_wp_q   <= cmd_wp_d;
            cmd_rp_q   <= cmd_rp_d;
            cmd_cnt_q  <= cmd_cnt_d;
            wdf_wp_q   <= wdf_wp_d;
            wdf_rp_q   <= wdf_rp_d;
            wdf_cnt_q  <= wdf_cnt_d;
            bitmap_q   <= bitmap_d;
            rd_vld_q   <= rd_vld_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            err_q      <= err_d;
            ref_ack_q  <= app_ref_req;
            zq_ack_q   <= app_zq_req;
        end
    end

    // Storage and read-data pipeline carry no reset; validity is tracked by the control flops above.
    always_ff @(posedge sys_clk_i) begin
        if (cmd_push) begin
            cmd_op_mem[cmd_wp_q]  <= app_cmd;
            cmd_idx_mem[cmd_wp_q] <= app_addr[ADDR_LSB +: MEM_AW];
        end
        if (wdf_push) begin
            wdf_data_mem[wdf_wp_q] <= app_wdf_data;
            wdf_mask_mem[wdf_wp_q] <= app_wdf_mask;
        end
        if (issue_wr) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (!wdf_mask_mem[wdf_rp_q][b]) mem[head_idx][b*8 +: 8] <= wdf_data_mem[wdf_rp_q][b*8 +: 8];
            end
        end
        if (issue_rd) rd_data_q[0] <= bitmap_q[head_idx] ? mem[head_idx] : UNWRITTEN;
        for (int i = 1; i < RD_LAT; i++) rd_data_q[i] <= rd_data_q[i-1];
    end

    assign ui_clk_sync_rst     = (state_q == ST_IDLE_RST);
    assign init_calib_complete = run;
    assign app_rdy             = cmd_rdy;
    assign app_wdf_rdy         = wdf_rdy;
    assign app_rd_data         = out_data_q;
    assign app_rd_data_valid   = out_vld_q;
    assign app_rd_data_end     = out_vld_q;
    assign app_ref_ack         = ref_ack_q;
    assign app_zq_ack          = zq_ack_q;
    assign app_sr_active       = 1'b0;
    assign cmd_err             = err_q;

endmodule
